// File: rtl/display_scan_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : display_scan_ctrl_pkg
//  Description : Shared display constants (mode encodings, anode-off pattern)
//                and the scroll-window index helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package display_scan_ctrl_pkg;

    localparam logic [1:0] c_mode_off    = 2'b00;
    localparam logic [1:0] c_mode_clock  = 2'b01;
    localparam logic [1:0] c_mode_scroll = 2'b10;
    localparam logic [3:0] c_anode_off   = 4'hF;

    // Buffer nibble shown at a digit position: the leftmost position (3)
    // shows the current offset, positions to the right show later symbols.
    function automatic logic [3:0] scroll_idx(input logic [5:0] li,
                                              input logic [1:0] addr,
                                              input int unsigned len);
        logic [6:0] w_sum;
        w_sum = {1'b0, li} + 7'd3 - {5'b0, addr};
        // li < len and the window spans at most 3 symbols, so one fold suffices
        if (w_sum >= 7'(len)) begin
            w_sum = w_sum - 7'(len);
        end
        return 4'(w_sum);
    endfunction

endpackage
`default_nettype wire

// File: rtl/display_scan_ctrl_sec_blink_gen.sv
`default_nettype none
// ============================================================================
//  Module      : sec_blink_gen
//  Description : Seconds-dot stretcher. Each tick holds the flag high for
//                BLINK_LEN clocks; a tick while high restarts the interval.
//  Revision    : 1.0 - initial release
// ============================================================================
module sec_blink_gen #(
    parameter int unsigned BLINK_LEN = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_sec_tick,
    output logic o_flag_sec
);

    localparam logic [23:0] c_load = 24'(BLINK_LEN - 1);

    logic [23:0] r_blink_cnt;
    logic        r_flag;

    // Load on tick, count down while lit, drop the flag once the count is spent
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_blink_cnt <= '0;
            r_flag      <= 1'b0;
        end else if (i_sec_tick) begin
            r_blink_cnt <= c_load;
            r_flag      <= 1'b1;
        end else if (r_flag) begin
            if (r_blink_cnt == '0) begin
                r_flag <= 1'b0;
            end else begin
                r_blink_cnt <= r_blink_cnt - 24'd1;
            end
        end
    end

    assign o_flag_sec = r_flag;

endmodule
`default_nettype wire

// File: rtl/display_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : display_scan_ctrl
//  Description : Four-digit multiplexed display scanner with hh:mm clock and
//                scrolling-text modes, frame-aligned input shadowing, anode
//                blanking and a seconds-dot generator.
//  Revision    : 1.0 - initial release
// ============================================================================
module display_scan_ctrl
    import display_scan_ctrl_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = 16,
    parameter int unsigned BLANK        = 2,
    parameter int unsigned SCROLL_STEPS = 64,
    parameter int unsigned LOOP_LEN     = 16,
    parameter int unsigned BLINK_LEN    = 1000
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic [1:0]  mode_in,
    input  logic [15:0] time_bcd,
    input  logic [63:0] scroll_data,
    input  logic        sec_tick,
    output logic [3:0]  digit,
    output logic [1:0]  address,
    output logic [1:0]  type_out,   // "type" is a reserved word in SystemVerilog
    output logic [5:0]  loopindex,
    output logic        flag_sec,
    output logic [3:0]  anode_n
);

    localparam logic [15:0] c_scan_last  = 16'(SCAN_DIV - 1);
    localparam logic [15:0] c_blank      = 16'(BLANK);
    localparam logic [9:0]  c_steps_last = 10'(SCROLL_STEPS - 1);
    localparam logic [5:0]  c_loop_last  = 6'(LOOP_LEN - 1);

    logic [15:0] r_scan_cnt;
    logic [1:0]  r_addr;
    logic [9:0]  r_frame_cnt;
    logic [5:0]  r_loopindex;
    logic [1:0]  r_sh_mode;
    logic [15:0] r_sh_time;
    logic [63:0] r_sh_scroll;
    logic [15:0] r_cnt_d;
    logic [3:0]  r_digit;
    logic [1:0]  r_address;
    logic [1:0]  r_type;
    logic [3:0]  r_anode_n;

    logic        w_frame_start;
    logic [1:0]  w_mode;
    logic [15:0] w_time;
    logic [63:0] w_scroll;
    logic        w_display_on;
    logic [9:0]  w_frame_nxt;
    logic [5:0]  w_li_nxt;
    logic [3:0]  w_idx;
    logic [3:0]  w_nib;

    // At a frame start the fresh inputs are used directly so the whole frame,
    // including its first slot, comes from one consistent snapshot.
    assign w_frame_start = (r_scan_cnt == '0) && (r_addr == 2'd0);
    assign w_mode        = w_frame_start ? mode_in     : r_sh_mode;
    assign w_time        = w_frame_start ? time_bcd    : r_sh_time;
    assign w_scroll      = w_frame_start ? scroll_data : r_sh_scroll;
    assign w_display_on  = (w_mode == c_mode_clock) || (w_mode == c_mode_scroll);

    // Scroll position: restart on entry into scroll mode, advance every SCROLL_STEPS frames
    always_comb begin
        w_frame_nxt = r_frame_cnt;
        w_li_nxt    = r_loopindex;
        if (w_mode != c_mode_scroll) begin
            w_frame_nxt = '0;
            w_li_nxt    = '0;
        end else if (w_frame_start) begin
            if (r_sh_mode != c_mode_scroll) begin
                w_frame_nxt = '0;
                w_li_nxt    = '0;
            end else if (r_frame_cnt == c_steps_last) begin
                w_frame_nxt = '0;
                w_li_nxt    = (r_loopindex == c_loop_last) ? 6'd0 : r_loopindex + 6'd1;
            end else begin
                w_frame_nxt = r_frame_cnt + 10'd1;
            end
        end
    end

    // Source nibble for the position being scanned
    always_comb begin
        w_idx = scroll_idx(w_li_nxt, r_addr, LOOP_LEN);
        w_nib = 4'd0;
        if (w_mode == c_mode_clock) begin
            w_nib = w_time[{r_addr, 2'b00} +: 4];
        end else if (w_mode == c_mode_scroll) begin
            w_nib = w_scroll[{w_idx, 2'b00} +: 4];
        end
    end

    // Slot/position counters, frame shadows and scroll state
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            r_scan_cnt  <= '0;
            r_addr      <= '0;
            r_frame_cnt <= '0;
            r_loopindex <= '0;
            r_sh_mode   <= '0;
            r_sh_time   <= '0;
            r_sh_scroll <= '0;
        end else begin
            if (r_scan_cnt == c_scan_last) begin
                r_scan_cnt <= '0;
                r_addr     <= r_addr + 2'd1;
            end else begin
                r_scan_cnt <= r_scan_cnt + 16'd1;
            end
            if (w_frame_start) begin
                r_sh_mode   <= mode_in;
                r_sh_time   <= time_bcd;
                r_sh_scroll <= scroll_data;
            end
            r_frame_cnt <= w_frame_nxt;
            r_loopindex <= w_li_nxt;
        end
    end

    // Decoder-facing outputs; anodes trail the segment data by one clock
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            r_digit   <= '0;
            r_address <= '0;
            r_type    <= '0;
            r_cnt_d   <= '0;
            r_anode_n <= c_anode_off;
        end else begin
            r_digit   <= w_nib;
            r_address <= r_addr;
            r_type    <= w_display_on ? w_mode : c_mode_off;
            r_cnt_d   <= r_scan_cnt;
            if (!w_display_on || (r_type == c_mode_off) || (r_cnt_d < c_blank)) begin
                r_anode_n <= c_anode_off;
            end else begin
                r_anode_n <= ~(4'b0001 << r_address);
            end
        end
    end

    sec_blink_gen #(
        .BLINK_LEN (BLINK_LEN)
    ) u_sec_blink (
        .clk        (clk_in),
        .rst_n      (rst_n_in),
        .i_sec_tick (sec_tick),
        .o_flag_sec (flag_sec)
    );

    assign digit     = r_digit;
    assign address   = r_address;
    assign type_out  = r_type;
    assign loopindex = r_loopindex;
    assign anode_n   = r_anode_n;

endmodule
`default_nettype wire

// File: doc/display_scan_ctrl.md
DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 Parameter SCAN_DIV, default 16: clocks per digit slot, range 4..65535.
REQ-002 Parameter BLANK, default 2: clocks at the start of each slot with all anodes off, range 1..SCAN_DIV-1.
REQ-003 Parameter SCROLL_STEPS, default 64: complete frames per scroll step, range 1..1023.
REQ-004 Parameter LOOP_LEN, default 16: scroll buffer length in nibbles, range 4..16.
REQ-005 Parameter BLINK_LEN, default 1000: clocks that flag_sec stays high after each sec_tick, range 1..2^24-1.
REQ-006 clk_in  input  1  single system clock; all logic on the rising edge.
REQ-007 rst_n_in  input  1  reset, synchronous, active-low.
REQ-008 mode_in  input  2  01 = hh:mm clock, 10 = scrolling text, 00/11 = display off.
REQ-009 time_bcd  input  16  four BCD nibbles; nibble a (bits 4a+3:4a) belongs to address a; address 3 is leftmost.
REQ-010 scroll_data  input  64  sixteen 4-bit symbol codes; nibble n occupies bits 4n+3:4n.
REQ-011 sec_tick  input  1  one-clock pulse once per decoded second.
REQ-012 digit  output  4  symbol code for the decoder.
REQ-013 address  output  2  digit position currently scanned.
REQ-014 type  output  2  display mode for the decoder.
REQ-015 loopindex  output  6  current scroll offset.
REQ-016 flag_sec  output  1  seconds-dot enable.
REQ-017 anode_n  output  4  active-low one-hot digit enable.

Function
REQ-018 scan_cnt shall count 0..SCAN_DIV-1 and wrap; on wrap, addr shall increment modulo 4.
REQ-019 A frame start is the cycle in which scan_cnt==0 and addr==0; the first cycle after reset release is a frame start.
REQ-020 At each frame start, mode_in, time_bcd and scroll_data shall be captured into shadow registers; outputs shall use shadow values only, so no frame mixes sources.
REQ-021 Registered outputs: address<=addr; type<=shadow mode, or 00 when the shadow mode is 00/11; digit<=source nibble for addr. This gives 1-cycle latency from the internal state.
REQ-022 In mode 01, the source nibble shall be time_bcd nibble addr, and loopindex shall be held at 0.
REQ-023 In mode 10, the source nibble shall be scroll_data nibble ((loopindex+3-addr) mod LOOP_LEN).
REQ-024 In mode 10, a frame counter shall increment at each frame start. On reaching SCROLL_STEPS, the frame counter shall clear and loopindex shall advance by 1, wrapping from LOOP_LEN-1 to 0.
REQ-025 When the shadow mode changes into 10 at a frame start, loopindex and the frame counter shall clear in that same cycle.
REQ-026 anode_n shall be registered from the previous cycle's address and scan_cnt: bit[address] is 0 when that scan_cnt>=BLANK, otherwise 4'hF. This aligns with the decoder's 1-cycle segment latency.
REQ-027 anode_n shall be 4'hF whenever the shadow mode is 00 or 11.
REQ-028 A sec_tick shall set flag_sec to 1 and load blink_cnt with BLINK_LEN-1. flag_sec shall clear on the cycle after blink_cnt reaches 0. A sec_tick arriving while flag_sec=1 shall reload blink_cnt (retrigger).
REQ-029 flag_sec shall be independent of mode; the decoder qualifies it.

Reset
REQ-030 While rst_n_in=0 at a clock edge, the following shall clear to 0: scan_cnt, addr, frame counter, blink_cnt, digit, address, type, loopindex, flag_sec and the shadow registers.
REQ-031 While rst_n_in=0 at a clock edge, anode_n shall be set to 4'hF.
REQ-032 A reset asserted mid-frame or mid-blink shall abort the frame or blink with no residual state; sec_tick is ignored during reset.

Structure
REQ-033 Mode encodings (OFF, CLOCK, SCROLL) and the anode-off constant shall live in the shared display package used by the decoder.
REQ-034 The flag_sec generator (blink_cnt plus retrigger) shall be a sub-module, sec_blink_gen; the scan, scroll and shadow logic shall stay in the top level.

Verification
REQ-035 Test parameters: SCAN_DIV=8, BLANK=2, mode 01, time_bcd=16'h1234. Required: address cycles 0,1,2,3 every 8 clocks; digit sequence 4,3,2,1; anode_n=4'hF for 2 clocks then the active bit low for 6 clocks, lagging address by 1.
REQ-036 Test: SCROLL_STEPS=2, LOOP_LEN=10, mode 10, scroll_data nibbles 0..9 = 0..9. Required: loopindex steps 0→1 after 2 frames and wraps 9→0; at loopindex=8, address 3..0 shows 8,9,0,1.
REQ-037 Test: change mode_in 01→10 mid-frame. Required: type and digit remain clock-mode until the next frame start; then type=10 and loopindex=0.
REQ-038 Test: BLINK_LEN=20; sec_tick at t0, then again at t0+10. Required: flag_sec high from t0+1 through t0+30 inclusive, then low.
REQ-039 Test: mode 11. Required: anode_n stays 4'hF and type=00.
REQ-040 Test: assert rst_n_in low for 1 clock mid-slot while scrolling. Required: next cycle all outputs at reset values, and scanning restarts at address 0 with loopindex 0.
